// File: rtl/conv_window_gen_pkg.sv
// Shared constants and helpers for the convolution window generator and the MAC block.
//   DEF_*     : default configuration of the window generator
//   elem_idx  : flat element index of window position (r, c) for a k x k kernel
package conv_window_gen_pkg;

   localparam int unsigned DEF_DATA_WIDTH  = 8;
   localparam int unsigned DEF_KERNEL_SIZE = 3;
   localparam int unsigned DEF_IMG_WIDTH   = 28;
   localparam int unsigned DEF_IMG_HEIGHT  = 28;

   // r = 0 is the oldest line, c = 0 the leftmost column
   function automatic int unsigned elem_idx(input int unsigned r,
                                            input int unsigned c,
                                            input int unsigned k);
      return r * k + c;
   endfunction

endpackage

// File: rtl/conv_window_gen_if.sv
// Pixel-in / window-out bus of conv_window_gen.
//   pixel_valid, pixel_in : raster-order pixel stream, no backpressure
//   sof                   : start-of-frame marker (only with CONV_WINDOW_SOF_EN)
//   window_valid          : window_in holds a complete window
//   window_in             : packed KERNEL_SIZE x KERNEL_SIZE window
//   frame_done            : one-cycle pulse with the last window of a frame
// Optional feature macro: CONV_WINDOW_SOF_EN
interface conv_window_gen_if #(
   parameter int unsigned DATA_WIDTH  = conv_window_gen_pkg::DEF_DATA_WIDTH,
   parameter int unsigned KERNEL_SIZE = conv_window_gen_pkg::DEF_KERNEL_SIZE
) ();

   logic                                        pixel_valid;
   logic [DATA_WIDTH-1:0]                       pixel_in;
`ifdef CONV_WINDOW_SOF_EN
   logic                                        sof;
`endif
   logic                                        window_valid;
   logic [DATA_WIDTH*KERNEL_SIZE*KERNEL_SIZE-1:0] window_in;
   logic                                        frame_done;

   // Pixel source side
   modport master (
      output pixel_valid, pixel_in,
`ifdef CONV_WINDOW_SOF_EN
      output sof,
`endif
      input  window_valid, window_in, frame_done
   );

   // Window generator side
   modport slave (
      input  pixel_valid, pixel_in,
`ifdef CONV_WINDOW_SOF_EN
      input  sof,
`endif
      output window_valid, window_in, frame_done
   );

endinterface

// File: rtl/conv_line_buffer.sv
// One line of pixel history: a DEPTH-deep RAM addressed by column.
// Reading addr returns the pixel written at that column one line earlier;
// the new pixel replaces it on the same edge.
//   clk        : clock
//   wr_en      : write wr_data at addr
//   addr       : current column
//   wr_data    : pixel entering this line
//   rd_data_c  : pixel leaving this line (combinational read)
module conv_line_buffer #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned DEPTH      = 28,
   parameter int unsigned ADDR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_W-1:0]     addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic [DATA_WIDTH-1:0] rd_data_c
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   assign rd_data_c = mem[addr];

   // RAM contents are never reset; stale data is masked by window_valid
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[addr] <= wr_data;
      end
   end

endmodule

// File: rtl/conv_window_gen.sv
// Sliding KERNEL_SIZE x KERNEL_SIZE window generator over a raster pixel stream
// (valid convolution, no padding). One-cycle latency from pixel to window.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : conv_window_gen_if.slave (pixel_valid, pixel_in, [sof],
//                window_valid, window_in, frame_done)
// Optional feature macro: CONV_WINDOW_SOF_EN adds bus.sof, which forces the
// accepted pixel to position (0,0) and drops any partial frame.
module conv_window_gen
   import conv_window_gen_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int unsigned KERNEL_SIZE = DEF_KERNEL_SIZE,
   parameter int unsigned IMG_WIDTH   = DEF_IMG_WIDTH,
   parameter int unsigned IMG_HEIGHT  = DEF_IMG_HEIGHT
) (
   input  logic           clk,
   input  logic           rst_n,
   conv_window_gen_if.slave bus
);

   localparam int unsigned COL_W  = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
   localparam int unsigned ROW_W  = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
   localparam int unsigned WIN_W  = DATA_WIDTH * KERNEL_SIZE * KERNEL_SIZE;
   localparam int unsigned NUM_LB = KERNEL_SIZE - 1;

   logic [COL_W-1:0]      col;
   logic [ROW_W-1:0]      row;
   logic [COL_W-1:0]      eff_col_c;
   logic [ROW_W-1:0]      eff_row_c;
   logic                  last_col_c;
   logic                  last_row_c;
   logic                  win_pos_c;

   logic [DATA_WIDTH-1:0] lb_wr   [NUM_LB];
   logic [DATA_WIDTH-1:0] lb_rd   [NUM_LB];
   logic [DATA_WIDTH-1:0] tap_c   [KERNEL_SIZE];
   logic [DATA_WIDTH-1:0] hist    [KERNEL_SIZE][KERNEL_SIZE-1];
   logic [WIN_W-1:0]      win_next_c;

   logic                  window_valid_q;
   logic [WIN_W-1:0]      window_q;
   logic                  frame_done_q;

   // Position of the pixel being accepted (sof overrides the counters)
   always_comb begin
      eff_col_c = col;
      eff_row_c = row;
`ifdef CONV_WINDOW_SOF_EN
      if (bus.sof) begin
         eff_col_c = '0;
         eff_row_c = '0;
      end
`endif
   end

   assign last_col_c = (eff_col_c == COL_W'(IMG_WIDTH - 1));
   assign last_row_c = (eff_row_c == ROW_W'(IMG_HEIGHT - 1));
   assign win_pos_c  = (eff_row_c >= ROW_W'(KERNEL_SIZE - 1)) &&
                       (eff_col_c >= COL_W'(KERNEL_SIZE - 1));

   // Raster position counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col <= '0;
         row <= '0;
      end else if (bus.pixel_valid) begin
         if (last_col_c) begin
            col <= '0;
            row <= last_row_c ? '0 : eff_row_c + ROW_W'(1);
         end else begin
            col <= eff_col_c + COL_W'(1);
            row <= eff_row_c;
         end
      end
   end

   // Line buffer chain: buffer 0 holds the previous line, buffer g the line g+1 back
   for (genvar g = 0; g < NUM_LB; g++) begin : g_lb
      if (g == 0) begin : g_head
         assign lb_wr[g] = bus.pixel_in;
      end else begin : g_chain
         assign lb_wr[g] = lb_rd[g-1];
      end

      conv_line_buffer #(
         .DATA_WIDTH (DATA_WIDTH),
         .DEPTH      (IMG_WIDTH),
         .ADDR_W     (COL_W)
      ) u_line_buffer (
         .clk       (clk),
         .wr_en     (bus.pixel_valid),
         .addr      (eff_col_c),
         .wr_data   (lb_wr[g]),
         .rd_data_c (lb_rd[g])
      );
   end

   // Column of pixels entering the window, tap 0 being the oldest line
   always_comb begin
      for (int unsigned r = 0; r < KERNEL_SIZE; r++) begin
         tap_c[r] = bus.pixel_in;
      end
      for (int unsigned r = 0; r < KERNEL_SIZE - 1; r++) begin
         tap_c[r] = lb_rd[KERNEL_SIZE - 2 - r];
      end
   end

   // Window = previous KERNEL_SIZE-1 columns plus the incoming column
   always_comb begin
      win_next_c = '0;
      for (int unsigned r = 0; r < KERNEL_SIZE; r++) begin
         for (int unsigned c = 0; c < KERNEL_SIZE; c++) begin
            if (c == KERNEL_SIZE - 1) begin
               win_next_c[elem_idx(r, c, KERNEL_SIZE)*DATA_WIDTH +: DATA_WIDTH] = tap_c[r];
            end else begin
               win_next_c[elem_idx(r, c, KERNEL_SIZE)*DATA_WIDTH +: DATA_WIDTH] = hist[r][c];
            end
         end
      end
   end

   // Column history shift and registered window outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned r = 0; r < KERNEL_SIZE; r++) begin
            for (int unsigned c = 0; c < KERNEL_SIZE - 1; c++) begin
               hist[r][c] <= '0;
            end
         end
         window_valid_q <= 1'b0;
         window_q       <= '0;
         frame_done_q   <= 1'b0;
      end else begin
         window_valid_q <= bus.pixel_valid && win_pos_c;
         frame_done_q   <= bus.pixel_valid && last_row_c && last_col_c;
         if (bus.pixel_valid) begin
            for (int unsigned r = 0; r < KERNEL_SIZE; r++) begin
               for (int unsigned c = 0; c + 1 < KERNEL_SIZE - 1; c++) begin
                  hist[r][c] <= hist[r][c+1];
               end
               hist[r][KERNEL_SIZE-2] <= tap_c[r];
            end
            if (win_pos_c) begin
               window_q <= win_next_c;
            end
         end
      end
   end

   assign bus.window_valid = window_valid_q;
   assign bus.window_in    = window_q;
   assign bus.frame_done   = frame_done_q;

endmodule

// File: doc/conv_window_gen.md
CONV_WINDOW_GEN -- requirements
Module: conv_window_gen

Interface
REQ-001 Parameter DATA_WIDTH, default 8: pixel bit width.
REQ-002 Parameter KERNEL_SIZE, default 3: window is KERNEL_SIZE x KERNEL_SIZE.
REQ-003 Parameter IMG_WIDTH, default 28: pixels per line, at least KERNEL_SIZE.
REQ-004 Parameter IMG_HEIGHT, default 28: lines per frame, at least KERNEL_SIZE.
REQ-005 clk  input  1  single clock; all state changes on the rising edge.
REQ-006 rst_n  input  1  reset, asynchronous and active-low.
REQ-007 pixel_valid  input  1  pixel_in is valid this cycle.
REQ-008 pixel_in  input  DATA_WIDTH  raster-order pixel stream.
REQ-009 window_valid  output  1  window_in holds a complete window.
REQ-010 window_in  output  DATA_WIDTH*KERNEL_SIZE*KERNEL_SIZE  packed window.
REQ-011 frame_done  output  1  one-cycle pulse when the last pixel of a frame is accepted.

Function
REQ-012 The block SHALL accept a pixel on every cycle where pixel_valid=1, with no backpressure; pixel_valid=0 cycles SHALL leave all state unchanged.
REQ-013 Counters col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1) SHALL give the position of the next pixel; an accepted pixel at col=IMG_WIDTH-1 wraps col to 0 and increments row; at row=IMG_HEIGHT-1 row wraps to 0.
REQ-014 KERNEL_SIZE-1 line buffers, each IMG_WIDTH deep, SHALL hold the previous lines; each accepted pixel is written and the oldest line's pixel at that column is read out.
REQ-015 Window element i=r*KERNEL_SIZE+c SHALL occupy bits (i+1)*DATA_WIDTH-1 down to i*DATA_WIDTH; r=0 is the oldest line, c=0 the leftmost column; the current pixel is element KERNEL_SIZE*KERNEL_SIZE-1.
REQ-016 Valid (no-padding) convolution: window_valid SHALL be 1 in the cycle after accepting a pixel at row>=KERNEL_SIZE-1 and col>=KERNEL_SIZE-1, and 0 otherwise. Windows never span a line boundary.
REQ-017 Latency: one cycle from the accepted pixel to its window; window_in SHALL hold its last value while window_valid=0.
REQ-018 A frame SHALL yield exactly (IMG_WIDTH-KERNEL_SIZE+1)*(IMG_HEIGHT-KERNEL_SIZE+1) windows.
REQ-019 frame_done SHALL pulse in the same cycle as the window for pixel (IMG_HEIGHT-1, IMG_WIDTH-1); the next accepted pixel starts a new frame at (0,0) with no dead cycle.
REQ-020 Line-buffer content from the previous frame SHALL never make a window valid; it is overwritten before use, per REQ-016.

Reset
REQ-021 While rst_n=0: window_valid=0, frame_done=0, window_in=0, col=0, row=0. Line-buffer RAM contents need not be cleared.
REQ-022 Asserting reset mid-frame SHALL abort the frame; the first pixel after release is (0,0).

Configuration
REQ-023 Macro CONV_WINDOW_SOF_EN SHALL add input sof (1 bit): a pixel accepted with sof=1 is treated as (0,0), with the counters forced and any partial frame discarded without a frame_done.
REQ-024 Without CONV_WINDOW_SOF_EN there SHALL be no sof port, and framing relies only on the counters from REQ-013.

Structure
REQ-025 The shared package SHALL hold the default DATA_WIDTH, KERNEL_SIZE, IMG_WIDTH and IMG_HEIGHT constants and the element-index helper (r*KERNEL_SIZE+c) shared with the MAC block.
REQ-026 One sub-module, conv_line_buffer, SHALL implement one IMG_WIDTH-deep delay line with write-enable and is instantiated KERNEL_SIZE-1 times.

Verification
REQ-027 K=3, 4x4 image, pixels 0..15 sent back to back -> 4 windows; the first is 0,1,2,4,5,6,8,9,10 at elements 0..8, the last is 5,6,7,9,10,11,13,14,15; frame_done pulses with the last window.
REQ-028 The same image with pixel_valid toggling every other cycle -> the same 4 windows in the same order, each one cycle after its pixel.
REQ-029 Two 4x4 frames back to back (values 0..15, then 100..115) -> 8 windows; the first window of frame 2 is 100,101,102,104,105,106,108,109,110.
REQ-030 Reset after pixel 9 of a frame, then a full frame 0..15 -> no window before pixel (2,2) of the new frame; exactly 4 correct windows.
REQ-031 With CONV_WINDOW_SOF_EN: 6 pixels, then sof with frame 0..15 -> 4 correct windows; no frame_done for the aborted partial frame.
REQ-032 Check every window against a reference model of the packing in REQ-015, with DATA_WIDTH=8 and the pixel value 8'hFF present, to confirm no sign or bit corruption.
